rs232_transmit_bare: RTL and testbench
======================================

Name: rs232_transmit_bare

Overview:
- Byte-wide RS-232 (8N1) serializer driving the board's rs232_rxd line toward the host.
- Counterpart of rs232_receive_bare; same CLOCK_FREQ/BAUD_RATE parameterisation.
- Accepts bytes over a valid/ready handshake into a one-entry holding register, so frames can go out back-to-back.
- Baud timing comes from a fractional accumulator, so non-integer ratios (e.g. 133 MHz / 12 Mbaud) average exactly.

Parameters:
- CLOCK_FREQ, 133000000: clock frequency in Hz.
- BAUD_RATE, 12000000: line rate in bit/s; must satisfy BAUD_RATE <= CLOCK_FREQ/2.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clock  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- data  input  8  byte to send; sampled when valid && ready.
- valid  input  1  data is valid.
- ready  output  1  holding register empty; transfer occurs on any rising edge with valid && ready.
- rs232_rxd  output  1  serial line, idle high; LSB first.
- busy  output  1  high while a frame is on the line or a byte is held.

Behaviour:
- Reset values (asynchronous, resetn low): rs232_rxd=1, ready=1, busy=0, state=IDLE, accumulator=0, holding register empty.
- Reset mid-frame truncates the frame immediately. The line returns high; no partial-frame recovery.
- Handshake:
  - ready = !hold_full, registered.
  - The accepting edge loads hold and sets hold_full.
  - ready drops the cycle after acceptance.
  - data and valid are ignored while ready=0.
- Baud tick:
  - Accumulator width is 32 bits.
  - Each cycle while not IDLE: if acc + BAUD_RATE >= CLOCK_FREQ, then acc <= acc + BAUD_RATE - CLOCK_FREQ and tick=1; otherwise acc <= acc + BAUD_RATE.
  - acc is cleared on the IDLE->START transition, so the first bit is full length.
  - Each bit lasts floor or ceil of CLOCK_FREQ/BAUD_RATE cycles. The long-run average is exact.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rs232_rxd=1. If hold_full: load shifter from hold, clear hold_full, go to START; rs232_rxd=0 is registered on that edge. Start-bit latency is 2 edges after the accepting edge.
  - START: on tick, go to DATA with bit index 0 and drive shifter[0].
  - DATA: on tick, shift right and increment the 3-bit index. After bit 7's tick, go to STOP and drive 1.
  - STOP: counts STOP_BITS ticks. On the final tick:
    - if hold_full: reload the shifter, clear hold_full, go to START and drive 0 on the same edge (no idle gap);
    - otherwise go to IDLE.
- Simultaneous accept and reload in the same cycle cannot occur, because reload requires hold_full and acceptance requires !hold_full.
- busy = (state != IDLE) || hold_full.

Optional Feature:
- Macro: RS232_TX_PARITY_EN.
- Defined: frame becomes 8E1/8E2. A PARITY state sits between DATA and STOP and drives the XOR of the 8 data bits (even parity), one bit time, on the same tick rules.
- Undefined: no PARITY state, no parity logic; frame is 8N1/8N2.

Decomposition:
- Package rs232_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - DATA_BITS=8;
  - ACC_WIDTH=32;
  - the idle line level constant.
  - Shared with the receiver later.
- Sub-module rs232_baud_gen:
  - inputs clock, resetn, clear, enable;
  - output tick;
  - contains the fractional accumulator.
- The FSM, shifter and holding register remain in rs232_transmit_bare.

Test Plan:
- CLOCK_FREQ=16, BAUD_RATE=1. Send 8'hA5 in idle.
  - rs232_rxd low 2 edges after acceptance.
  - Bits 1,0,1,0,0,1,0,1 follow, each exactly 16 cycles, then 16 cycles high.
  - busy falls after the stop bit.
- Back-to-back: valid held high with 8'h00 then 8'hFF.
  - ready drops after the first accept and rises on the edge that the hold register empties (start of the first frame).
  - Second start bit immediately follows the first stop bit, with zero idle cycles.
  - Total is 320 cycles of frame time.
- CLOCK_FREQ=133000000, BAUD_RATE=12000000, 100 frames of 8'h55:
  - each bit is 11 or 12 cycles;
  - 1000 bits span 11083 or 11084 cycles.
- Reset asserted mid-DATA:
  - rs232_rxd=1, ready=1, busy=0 asynchronously.
  - After release, a new byte 8'h3C transmits correctly.
- Acceptance rules:
  - valid pulsed while ready=0: the byte is ignored and not transmitted.
  - valid && ready in the final STOP cycle: the byte is held and sent next.
- With RS232_TX_PARITY_EN, send 8'h07: parity bit=1 precedes the stop bit. Send 8'h03: parity bit=0.

Source files
------------

// File: rtl/rs232_pkg.sv
// rs232_pkg: shared RS-232 definitions for the transmitter, and later for the
// receiver.
//   state_e    : serializer FSM states. PARITY is only entered when the
//                RS232_TX_PARITY_EN macro is defined.
//   DATA_BITS  : payload width of one frame.
//   ACC_WIDTH  : width of the fractional baud accumulator.
//   LINE_IDLE  : level of the serial line between frames (mark).
//   even_parity: XOR of the data bits.
package rs232_pkg;

  localparam int   DATA_BITS = 8;
  localparam int   ACC_WIDTH = 32;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rs232_transmit_bare_if.sv
// rs232_transmit_bare_if: byte handshake into the RS-232 transmitter.
//   data  : byte to send (master -> slave)
//   valid : data is valid (master -> slave)
//   ready : holding register empty (slave -> master)
// A byte transfers on any rising clock edge where valid && ready.
interface rs232_transmit_bare_if;
  import rs232_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/rs232_baud_gen.sv
// rs232_baud_gen: fractional baud-rate tick generator.
//   clock  : system clock
//   resetn : asynchronous active-low reset
//   clear  : zero the accumulator so the next bit is full length
//   enable : advance the accumulator this cycle
//   tick   : combinational, high in the last cycle of each bit time
// The accumulator gains BAUD_RATE every enabled cycle and wraps by CLOCK_FREQ,
// so bit lengths alternate between floor and ceil of CLOCK_FREQ/BAUD_RATE and
// the long-run rate is exact.
module rs232_baud_gen
  import rs232_pkg::*;
#(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 12000000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  // One extra bit so acc + BAUD_RATE cannot overflow before the compare.
  localparam logic [ACC_WIDTH:0] BAUD_INC  = (ACC_WIDTH+1)'(BAUD_RATE);
  localparam logic [ACC_WIDTH:0] CLOCK_LIM = (ACC_WIDTH+1)'(CLOCK_FREQ);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH:0]   sum_s;

  // Accumulator next state and tick decode.
  always_comb begin
    sum_s = {1'b0, acc_q} + BAUD_INC;
    tick  = 1'b0;
    acc_d = acc_q;
    if (clear) begin
      acc_d = {ACC_WIDTH{1'b0}};
    end else if (enable) begin
      if (sum_s >= CLOCK_LIM) begin
        tick  = 1'b1;
        acc_d = ACC_WIDTH'(sum_s - CLOCK_LIM);
      end else begin
        acc_d = sum_s[ACC_WIDTH-1:0];
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_q <= {ACC_WIDTH{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/rs232_transmit_bare.sv
// rs232_transmit_bare: byte-wide RS-232 serializer, 8N1 / 8N2, LSB first.
//   clock     : system clock
//   resetn    : asynchronous active-low reset (truncates any frame in flight)
//   tx        : slave side of rs232_transmit_bare_if (data/valid in, ready out)
//   rs232_rxd : serial line toward the host, idle high, registered
//   busy      : frame on the line or byte held, registered
// A one-entry holding register lets the next byte wait during a frame so that
// frames go out back to back with no idle gap.
// Optional: define RS232_TX_PARITY_EN for an even parity bit between the data
// and stop bits (8E1 / 8E2).
module rs232_transmit_bare
  import rs232_pkg::*;
#(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 12000000,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  rs232_transmit_bare_if.slave tx,
  output logic                 rs232_rxd,
  output logic                 busy
);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 ready_q, ready_d;
  logic                 rxd_q, rxd_d;
  logic                 busy_q, busy_d;
`ifdef RS232_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  logic tick_s;
  logic clear_s;
  logic load_s;
  logic accept_s;
  logic stop_last_s;

  assign tx.ready  = ready_q;
  assign rs232_rxd = rxd_q;
  assign busy      = busy_q;

  rs232_baud_gen #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) u_baud (
    .clock  (clock),
    .resetn (resetn),
    .clear  (clear_s),
    .enable (state_q != IDLE),
    .tick   (tick_s)
  );

  // With two stop bits the first stop tick only advances the counter.
  assign stop_last_s = (STOP_BITS == 2) ? stop_cnt_q : 1'b1;

  // FSM next state, shifter, holding register and registered line level.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    idx_d       = idx_q;
    stop_cnt_d  = stop_cnt_q;
    rxd_d       = rxd_q;
    clear_s     = 1'b0;
    load_s      = 1'b0;
    accept_s    = tx.valid && ready_q;
`ifdef RS232_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      IDLE: begin
        rxd_d = LINE_IDLE;
        if (hold_full_q) begin
          // Clearing the accumulator here makes the start bit full length.
          load_s  = 1'b1;
          clear_s = 1'b1;
          state_d = START;
          rxd_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          state_d = DATA;
          idx_d   = 3'd0;
          rxd_d   = shift_q[0];
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef RS232_TX_PARITY_EN
            state_d = PARITY;
            rxd_d   = parity_q;
`else
            state_d    = STOP;
            stop_cnt_d = 1'b0;
            rxd_d      = LINE_IDLE;
`endif
          end else begin
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            idx_d   = idx_q + 3'd1;
            rxd_d   = shift_q[1];
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
`ifdef RS232_TX_PARITY_EN
        if (tick_s) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          rxd_d      = LINE_IDLE;
        end else begin
          state_d = PARITY;
        end
`else
        // Not reachable in the no-parity build; recover to idle.
        state_d = IDLE;
        rxd_d   = LINE_IDLE;
`endif
      end
      STOP: begin
        if (tick_s) begin
          if (!stop_last_s) begin
            stop_cnt_d = 1'b1;
          end else if (hold_full_q) begin
            // Next byte already waiting: start bit follows with no idle gap.
            load_s  = 1'b1;
            state_d = START;
            rxd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            rxd_d   = LINE_IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        rxd_d   = LINE_IDLE;
      end
    endcase

    // load needs hold_full_q and accept needs !hold_full_q, so they never coincide.
    if (load_s) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
`ifdef RS232_TX_PARITY_EN
      parity_d    = even_parity(hold_q);
`endif
    end else if (accept_s) begin
      hold_d      = tx.data;
      hold_full_d = 1'b1;
    end else begin
      hold_full_d = hold_full_q;
    end
  end

  // Flag outputs are derived from next state so they stay registered.
  always_comb begin
    ready_d = !hold_full_d;
    busy_d  = (state_d != IDLE) || hold_full_d;
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      shift_q     <= {DATA_BITS{1'b0}};
      hold_q      <= {DATA_BITS{1'b0}};
      hold_full_q <= 1'b0;
      idx_q       <= 3'd0;
      stop_cnt_q  <= 1'b0;
      ready_q     <= 1'b1;
      rxd_q       <= LINE_IDLE;
      busy_q      <= 1'b0;
`ifdef RS232_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      idx_q       <= idx_d;
      stop_cnt_q  <= stop_cnt_d;
      ready_q     <= ready_d;
      rxd_q       <= rxd_d;
      busy_q      <= busy_d;
`ifdef RS232_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_rs232_transmit_bare.sv
`timescale 1ns/1ps
// Directed bench for rs232_transmit_bare. DUT A runs at 16 clocks per bit,
// DUT B at 133 MHz / 12 Mbaud for the fractional-rate measurement.
module tb_rs232_transmit_bare;

  localparam int A_CF  = 16;
  localparam int A_BR  = 1;
  localparam int B_CF  = 133000000;
  localparam int B_BR  = 12000000;
  localparam int A_BIT = 16;
`ifdef RS232_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int SPAN_LO    = 12191;
  localparam int SPAN_HI    = 12192;
`else
  localparam int FRAME_BITS = 10;
  localparam int SPAN_LO    = 11083;
  localparam int SPAN_HI    = 11084;
`endif
  localparam int A_FRAME = FRAME_BITS * A_BIT;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic rxd_a, busy_a, rxd_b, busy_b;

  rs232_transmit_bare_if if_a ();
  rs232_transmit_bare_if if_b ();

  rs232_transmit_bare #(.CLOCK_FREQ(A_CF), .BAUD_RATE(A_BR), .STOP_BITS(1)) dut_a (
    .clock(clock), .resetn(resetn), .tx(if_a), .rs232_rxd(rxd_a), .busy(busy_a));

  rs232_transmit_bare #(.CLOCK_FREQ(B_CF), .BAUD_RATE(B_BR), .STOP_BITS(1)) dut_b (
    .clock(clock), .resetn(resetn), .tx(if_b), .rs232_rxd(rxd_b), .busy(busy_b));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int  acc_cnt, trans, first, last, cyc, end_cyc;
  bit  done;
  logic prev;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int bi);
    if (bi == 0) return 1'b0;
    else if (bi <= 8) return b[bi-1];
`ifdef RS232_TX_PARITY_EN
    else if (bi == 9) return ^b;
`endif
    else return 1'b1;
  endfunction

  // Checks line and busy of DUT A for frame cycles [c0, c1); frame cycle 0 is
  // the first sample after the edge that drove the start bit.
  task automatic frame_a(input logic [7:0] b, input int c0, input int c1, input string tag);
    for (int c = c0; c < c1; c++) begin
      check1(tag, rxd_a, exp_bit(b, c / A_BIT));
      check1({tag, "_busy"}, busy_a, 1'b1);
      step(1);
    end
  endtask

  // Sends a byte on DUT A from idle and stops at frame cycle 0.
  task automatic send_a(input logic [7:0] b, input string tag);
    if_a.data  = b;
    if_a.valid = 1'b1;
    step(1);
    if_a.valid = 1'b0;
    step(1);
    check1({tag, "_start"}, rxd_a, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.data = 8'h00; if_a.valid = 1'b0;
    if_b.data = 8'h00; if_b.valid = 1'b0;
    resetn = 1'b0;
    #12;
    check1("rst_rxd", rxd_a, 1'b1);
    check1("rst_ready", if_a.ready, 1'b1);
    check1("rst_busy", busy_a, 1'b0);
    check1("rst_rxd_b", rxd_b, 1'b1);
    @(negedge clock);
    resetn = 1'b1;
    step(2);

    // Single frame 8'hA5 from idle.
    if_a.data  = 8'hA5;
    if_a.valid = 1'b1;
    step(1);
    if_a.valid = 1'b0;
    check1("t1_rxd_after_accept", rxd_a, 1'b1);
    check1("t1_ready_drop", if_a.ready, 1'b0);
    check1("t1_busy", busy_a, 1'b1);
    step(1);
    check1("t1_start_latency", rxd_a, 1'b0);
    check1("t1_ready_rise", if_a.ready, 1'b1);
    frame_a(8'hA5, 0, A_FRAME, "t1_frame");
    check1("t1_busy_end", busy_a, 1'b0);
    check1("t1_rxd_end", rxd_a, 1'b1);

    // Back-to-back 8'h00 then 8'hFF with valid held high.
    step(2);
    if_a.data  = 8'h00;
    if_a.valid = 1'b1;
    step(1);
    if_a.data = 8'hFF;
    check1("t2_ready_drop", if_a.ready, 1'b0);
    step(1);
    check1("t2_ready_rise", if_a.ready, 1'b1);
    frame_a(8'h00, 0, 80, "t2_frame0");
    check1("t2_ready_held", if_a.ready, 1'b0);
    frame_a(8'h00, 80, A_FRAME, "t2_frame0");
    if_a.valid = 1'b0;
    check1("t2_ready_reload", if_a.ready, 1'b1);
    frame_a(8'hFF, 0, A_FRAME, "t2_frame1");
    check1("t2_busy_end", busy_a, 1'b0);

    // 100 frames of 8'h55 at 133 MHz / 12 Mbaud.
    step(2);
    acc_cnt = 0; trans = 0; first = -1; last = -1; cyc = 0; end_cyc = -1; done = 1'b0;
    if_b.data  = 8'h55;
    if_b.valid = 1'b1;
    prev = rxd_b;
    while (cyc < 20000 && !done) begin
      if (acc_cnt == 100) if_b.valid = 1'b0;
      if (if_b.valid && if_b.ready) acc_cnt++;
      step(1);
      if (rxd_b !== prev) begin
`ifndef RS232_TX_PARITY_EN
        if (first >= 0) check1("t3_bit_len", ((cyc - last) == 11) || ((cyc - last) == 12), 1'b1);
`endif
        if (first < 0) first = cyc;
        trans++;
        last = cyc;
        prev = rxd_b;
      end
      if (first >= 0 && !busy_b) begin
        done = 1'b1;
        end_cyc = cyc;
      end
      cyc++;
    end
    if_b.valid = 1'b0;
    check1("t3_done", done, 1'b1);
    check32("t3_frames", acc_cnt, 100);
    check1("t3_span", ((end_cyc - first) == SPAN_LO) || ((end_cyc - first) == SPAN_HI), 1'b1);
`ifndef RS232_TX_PARITY_EN
    check32("t3_transitions", trans, 1000);
    check1("t3_last_bit_len", ((end_cyc - last) == 11) || ((end_cyc - last) == 12), 1'b1);
`endif

    // Reset asserted mid-DATA, then 8'h3C.
    step(2);
    send_a(8'hF0, "t4_pre");
    frame_a(8'hF0, 0, 40, "t4_pre");
    #1 resetn = 1'b0;
    #1;
    check1("t4_rst_rxd", rxd_a, 1'b1);
    check1("t4_rst_ready", if_a.ready, 1'b1);
    check1("t4_rst_busy", busy_a, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    step(2);
    check1("t4_idle_rxd", rxd_a, 1'b1);
    send_a(8'h3C, "t4");
    frame_a(8'h3C, 0, A_FRAME, "t4_frame");
    check1("t4_busy_end", busy_a, 1'b0);

    // valid pulsed while ready=0 is ignored.
    step(2);
    if_a.data  = 8'h81;
    if_a.valid = 1'b1;
    step(1);
    check1("t5_ready_low", if_a.ready, 1'b0);
    if_a.data = 8'h7E;
    step(1);
    if_a.valid = 1'b0;
    check1("t5_start", rxd_a, 1'b0);
    frame_a(8'h81, 0, A_FRAME, "t5_frame");
    check1("t5_busy_end", busy_a, 1'b0);
    trans = 0;
    for (int i = 0; i < 40; i++) begin
      if (rxd_a !== 1'b1 || busy_a !== 1'b0) trans++;
      step(1);
    end
    check32("t5_ignored_byte", trans, 0);

    // Accept in the final STOP cycle: held, then sent after one idle cycle.
    send_a(8'h96, "t6");
    frame_a(8'h96, 0, A_FRAME - 1, "t6_frame");
    check1("t6_last_stop_ready", if_a.ready, 1'b1);
    if_a.data  = 8'h5A;
    if_a.valid = 1'b1;
    step(1);
    if_a.valid = 1'b0;
    check1("t6_gap_rxd", rxd_a, 1'b1);
    check1("t6_gap_busy", busy_a, 1'b1);
    check1("t6_gap_ready", if_a.ready, 1'b0);
    step(1);
    check1("t6_start", rxd_a, 1'b0);
    frame_a(8'h5A, 0, A_FRAME, "t6_frame2");
    check1("t6_busy_end", busy_a, 1'b0);

`ifdef RS232_TX_PARITY_EN
    // Even parity: 8'h07 has three ones, 8'h03 has two.
    step(2);
    send_a(8'h07, "t7");
    frame_a(8'h07, 0, 9 * A_BIT + 8, "t7_frame07");
    check1("t7_parity07", rxd_a, 1'b1);
    frame_a(8'h07, 9 * A_BIT + 8, A_FRAME, "t7_frame07");
    step(2);
    send_a(8'h03, "t7");
    frame_a(8'h03, 0, 9 * A_BIT + 8, "t7_frame03");
    check1("t7_parity03", rxd_a, 1'b0);
    frame_a(8'h03, 9 * A_BIT + 8, A_FRAME, "t7_frame03");
    check1("t7_busy_end", busy_a, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
